// File: rtl/motor_pkg.sv
// Shared types and constants for the multi-channel H-bridge ramp driver.
// Holds the per-channel state enum, direction encodings and a width helper.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DRAIN,
    ST_DEAD
  } state_e;

  localparam logic [1:0] CHOOSE_FWD = 2'b01;
  localparam logic [1:0] CHOOSE_REV = 2'b10;

  // Counter width that stays >= 1 even for a modulus of 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motor_channel_fsm.sv
// One H-bridge channel: STOP/RUN/DRAIN/DEAD FSM, duty ramp, dead time, PWM.
// Ports: clk, rst_ni (async low), tick_i (ramp step), cnt_i (period count),
//   choose_i (dir cmd), speed_i; pwm1_o/pwm2_o (fwd/rev), duty_o, busy_o.
module motor_channel_fsm
  import motor_pkg::*;
#(
  parameter int SPEED_W = 2,
  parameter int STEP    = 5,
  parameter int PERIOD  = 50,
  parameter int DEAD    = 100,
  localparam int DW     = $clog2(PERIOD + 1)
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic [DW-1:0]      cnt_i,
  input  logic [1:0]         choose_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               pwm1_o,
  output logic               pwm2_o,
  output logic [DW-1:0]      duty_o,
  output logic               busy_o
);

  localparam int DCW = cw(DEAD);
  localparam logic [DCW-1:0] DEAD_INIT = DCW'(DEAD - 1);

  state_e         state_q, state_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           rev_q, rev_d;
  logic           pwm1_q, pwm1_d;
  logic           pwm2_q, pwm2_d;

  logic          is_fwd, is_rev, brake;
  logic          same_dir, opp_dir;
  logic [31:0]   prod;
  logic [DW-1:0] target;

  assign is_fwd   = (choose_i == CHOOSE_FWD);
  assign is_rev   = (choose_i == CHOOSE_REV);
  assign brake    = !(is_fwd || is_rev);
  assign same_dir = rev_q ? is_rev : is_fwd;
  assign opp_dir  = rev_q ? is_fwd : is_rev;

  // Wide product so large speed*STEP clamps instead of wrapping.
  assign prod   = 32'(speed_i) * 32'(STEP);
  assign target = (prod > 32'(PERIOD)) ? DW'(PERIOD) : DW'(prod);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_STOP;
      duty_q  <= '0;
      dcnt_q  <= '0;
      rev_q   <= 1'b0;
      pwm1_q  <= 1'b0;
      pwm2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dcnt_q  <= dcnt_d;
      rev_q   <= rev_d;
      pwm1_q  <= pwm1_d;
      pwm2_q  <= pwm2_d;
    end
  end

  // A state change always suppresses the duty step of a coincident tick.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dcnt_d  = dcnt_q;
    rev_d   = rev_q;
    unique case (state_q)
      ST_STOP: begin
        duty_d = '0;
        if (!brake) begin
          rev_d   = is_rev;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (brake) begin
          state_d = ST_STOP;
          duty_d  = '0;
        end else if (opp_dir) begin
          state_d = ST_DRAIN;
        end else if (tick_i) begin
          if (duty_q < target)
            duty_d = duty_q + DW'(1);
          else if (duty_q > target)
            duty_d = duty_q - DW'(1);
        end
      end
      ST_DRAIN: begin
        if (brake) begin
          state_d = ST_STOP;
          duty_d  = '0;
        end else if (same_dir) begin
          state_d = ST_RUN;
        end else if (duty_q == '0) begin
          state_d = ST_DEAD;
          dcnt_d  = DEAD_INIT;
        end else if (tick_i) begin
          duty_d = duty_q - DW'(1);
        end
      end
      ST_DEAD: begin
        if (brake) begin
          state_d = ST_STOP;
          duty_d  = '0;
        end else if (dcnt_q == '0) begin
          rev_d   = is_rev;
          state_d = ST_RUN;
          duty_d  = '0;
        end else begin
          dcnt_d = dcnt_q - DCW'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        duty_d  = '0;
      end
    endcase
  end

  // Gate on the next state so a brake silences the bridge with duty_o.
  always_comb begin
    pwm1_d = 1'b0;
    pwm2_d = 1'b0;
    if ((state_d == ST_RUN || state_d == ST_DRAIN) && (cnt_i < duty_q)) begin
      if (rev_d)
        pwm2_d = 1'b1;
      else
        pwm1_d = 1'b1;
    end
  end

  assign pwm1_o = pwm1_q;
  assign pwm2_o = pwm2_q;
  assign duty_o = duty_q;
  assign busy_o = (state_q == ST_DRAIN) || (state_q == ST_DEAD);

endmodule

// File: rtl/motor_driver_ramp.sv
// Multi-channel H-bridge PWM driver with duty ramping and reversal dead time.
// Ports: clk, rst (async low), choose/speed per channel in;
//   pwm_out1/pwm_out2 bridge drives, duty_out, busy per channel out.
module motor_driver_ramp
  import motor_pkg::*;
#(
  parameter int CH       = 2,
  parameter int SPEED_W  = 2,
  parameter int STEP     = 5,
  parameter int PERIOD   = 50,
  parameter int RAMP_DIV = 4,
  parameter int DEAD     = 100,
  localparam int DW      = $clog2(PERIOD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CH-1:0]       choose,
  input  logic [SPEED_W*CH-1:0] speed,
  output logic [CH-1:0]         pwm_out1,
  output logic [CH-1:0]         pwm_out2,
  output logic [DW*CH-1:0]      duty_out,
  output logic [CH-1:0]         busy
);

  localparam int CW = cw(PERIOD);
  localparam int RW = cw(RAMP_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          wrap, tick;
  logic [DW-1:0] cnt_w;

  assign wrap  = (cnt_q == CW'(PERIOD - 1));
  assign tick  = wrap && (rcnt_q == RW'(RAMP_DIV - 1));
  assign cnt_w = DW'(cnt_q);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    rcnt_d = rcnt_q;
    if (wrap)
      rcnt_d = tick ? '0 : rcnt_q + RW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      rcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    motor_channel_fsm #(
      .SPEED_W (SPEED_W),
      .STEP    (STEP),
      .PERIOD  (PERIOD),
      .DEAD    (DEAD)
    ) u_ch (
      .clk      (clk),
      .rst_ni   (rst),
      .tick_i   (tick),
      .cnt_i    (cnt_w),
      .choose_i (choose[2*g +: 2]),
      .speed_i  (speed[SPEED_W*g +: SPEED_W]),
      .pwm1_o   (pwm_out1[g]),
      .pwm2_o   (pwm_out2[g]),
      .duty_o   (duty_out[DW*g +: DW]),
      .busy_o   (busy[g])
    );
  end

endmodule

// File: tb/tb_motor_driver_ramp.sv
// Self-checking bench: default 2-channel driver plus a 4-channel variant,
// both compared every cycle against a spec-level behavioural model.
module tb_motor_driver_ramp;

  localparam int SW   = 2;
  localparam int CH_A = 2;
  localparam int P_A  = 50;
  localparam int S_A  = 5;
  localparam int R_A  = 4;
  localparam int D_A  = 100;
  localparam int DW_A = $clog2(P_A + 1);
  localparam int CH_B = 4;
  localparam int P_B  = 20;
  localparam int S_B  = 10;
  localparam int R_B  = 4;
  localparam int D_B  = 100;
  localparam int DW_B = $clog2(P_B + 1);
  localparam int WA   = CH_A * (3 + DW_A);
  localparam int WB   = CH_B * (3 + DW_B);

  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DEAD  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2*CH_A-1:0]  choose_a = '0;
  logic [SW*CH_A-1:0] speed_a  = '0;
  logic [CH_A-1:0]    pwm1_a, pwm2_a, busy_a;
  logic [DW_A*CH_A-1:0] duty_a;

  logic [2*CH_B-1:0]  choose_b = '0;
  logic [SW*CH_B-1:0] speed_b  = '0;
  logic [CH_B-1:0]    pwm1_b, pwm2_b, busy_b;
  logic [DW_B*CH_B-1:0] duty_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motor_driver_ramp u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .choose   (choose_a),
    .speed    (speed_a),
    .pwm_out1 (pwm1_a),
    .pwm_out2 (pwm2_a),
    .duty_out (duty_a),
    .busy     (busy_a)
  );

  motor_driver_ramp #(
    .CH       (CH_B),
    .SPEED_W  (SW),
    .STEP     (S_B),
    .PERIOD   (P_B),
    .RAMP_DIV (R_B),
    .DEAD     (D_B)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .choose   (choose_b),
    .speed    (speed_b),
    .pwm_out1 (pwm1_b),
    .pwm_out2 (pwm2_b),
    .duty_out (duty_b),
    .busy     (busy_b)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int st;
    int duty;
    int dcnt;
    int rev;
    int p1;
    int p2;
  } chm_t;

  function automatic chm_t ch_rst();
    chm_t c;
    c = '0;
    c.st = M_STOP;
    return c;
  endfunction

  function automatic chm_t ch_next(input chm_t c, input int ch, input int sp,
                                   input int cnt, input bit tk,
                                   input int period, input int step,
                                   input int dead);
    chm_t n;
    int   tgt;
    bit   fwd, rv, brk, same, opp;
    n    = c;
    fwd  = (ch == 1);
    rv   = (ch == 2);
    brk  = !(fwd || rv);
    same = (c.rev != 0) ? rv : fwd;
    opp  = (c.rev != 0) ? fwd : rv;
    tgt  = (sp * step > period) ? period : sp * step;
    if (c.st == M_STOP) begin
      if (!brk) begin
        n.st  = M_RUN;
        n.rev = rv ? 1 : 0;
      end
    end else if (brk) begin
      n.st   = M_STOP;
      n.duty = 0;
    end else if (c.st == M_RUN) begin
      if (opp)
        n.st = M_DRAIN;
      else if (tk && c.duty != tgt)
        n.duty = c.duty + ((c.duty < tgt) ? 1 : -1);
    end else if (c.st == M_DRAIN) begin
      if (same) begin
        n.st = M_RUN;
      end else if (c.duty == 0) begin
        n.st   = M_DEAD;
        n.dcnt = dead - 1;
      end else if (tk) begin
        n.duty = c.duty - 1;
      end
    end else begin
      if (c.dcnt == 0) begin
        n.st   = M_RUN;
        n.rev  = rv ? 1 : 0;
        n.duty = 0;
      end else begin
        n.dcnt = c.dcnt - 1;
      end
    end
    n.p1 = ((n.st == M_RUN || n.st == M_DRAIN) && n.rev == 0 && cnt < c.duty) ? 1 : 0;
    n.p2 = ((n.st == M_RUN || n.st == M_DRAIN) && n.rev != 0 && cnt < c.duty) ? 1 : 0;
    return n;
  endfunction

  chm_t ma [CH_A];
  chm_t mb [CH_B];
  int   ca, ra, cb, rb;
  logic tka, tkb;

  assign tka = (ca == P_A - 1) && (ra == R_A - 1);
  assign tkb = (cb == P_B - 1) && (rb == R_B - 1);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ca <= 0;
      ra <= 0;
      for (int i = 0; i < CH_A; i++) ma[i] <= ch_rst();
    end else begin
      for (int i = 0; i < CH_A; i++)
        ma[i] <= ch_next(ma[i], int'(choose_a[2*i +: 2]), int'(speed_a[SW*i +: SW]),
                         ca, tka, P_A, S_A, D_A);
      ca <= (ca == P_A - 1) ? 0 : ca + 1;
      if (ca == P_A - 1) ra <= tka ? 0 : ra + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cb <= 0;
      rb <= 0;
      for (int j = 0; j < CH_B; j++) mb[j] <= ch_rst();
    end else begin
      for (int j = 0; j < CH_B; j++)
        mb[j] <= ch_next(mb[j], int'(choose_b[2*j +: 2]), int'(speed_b[SW*j +: SW]),
                         cb, tkb, P_B, S_B, D_B);
      cb <= (cb == P_B - 1) ? 0 : cb + 1;
      if (cb == P_B - 1) rb <= tkb ? 0 : rb + 1;
    end
  end

  logic [CH_A-1:0]      ea1, ea2, eab;
  logic [DW_A*CH_A-1:0] ead;
  logic [CH_B-1:0]      eb1, eb2, ebb;
  logic [DW_B*CH_B-1:0] ebd;
  logic [WA-1:0] exp_a, obs_a;
  logic [WB-1:0] exp_b, obs_b;

  always_comb begin
    ea1 = '0;
    ea2 = '0;
    eab = '0;
    ead = '0;
    for (int i = 0; i < CH_A; i++) begin
      ea1[i] = (ma[i].p1 != 0);
      ea2[i] = (ma[i].p2 != 0);
      eab[i] = (ma[i].st == M_DRAIN) || (ma[i].st == M_DEAD);
      ead[DW_A*i +: DW_A] = ma[i].duty[DW_A-1:0];
    end
  end

  always_comb begin
    eb1 = '0;
    eb2 = '0;
    ebb = '0;
    ebd = '0;
    for (int j = 0; j < CH_B; j++) begin
      eb1[j] = (mb[j].p1 != 0);
      eb2[j] = (mb[j].p2 != 0);
      ebb[j] = (mb[j].st == M_DRAIN) || (mb[j].st == M_DEAD);
      ebd[DW_B*j +: DW_B] = mb[j].duty[DW_B-1:0];
    end
  end

  assign exp_a = {ea1, ea2, ead, eab};
  assign obs_a = {pwm1_a, pwm2_a, duty_a, busy_a};
  assign exp_b = {eb1, eb2, ebd, ebb};
  assign obs_b = {pwm1_b, pwm2_b, duty_b, busy_b};

  function automatic int da(input int i);
    return int'(duty_a[DW_A*i +: DW_A]);
  endfunction

  function automatic int db(input int i);
    return int'(duty_b[DW_B*i +: DW_B]);
  endfunction

  function automatic logic [1:0] rand_dir();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b11;
    if (r < 6)  return 2'b01;
    return 2'b10;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs_a !== '0) begin
      n_err++;
      $display("FAIL reset_a got %h want 0", obs_a);
    end
    n_chk++;
    if (obs_b !== '0) begin
      n_err++;
      $display("FAIL reset_b got %h want 0", obs_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    int h1, h2;
    choose_a[1:0] = 2'b01;
    speed_a[1:0]  = 2'd3;
    repeat (64 * P_A) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        n_err++;
        $display("FAIL ramp a=%h want %h b=%h want %h", obs_a, exp_a, obs_b, exp_b);
      end
    end
    h1 = 0;
    h2 = 0;
    repeat (P_A) begin
      @(negedge clk);
      if (pwm1_a[0]) h1++;
      if (pwm2_a[0]) h2++;
    end
    n_chk++;
    if (da(0) != 15) begin
      n_err++;
      $display("FAIL ramp_duty got %0d want 15", da(0));
    end
    n_chk++;
    if (h1 != 15 || h2 != 0) begin
      n_err++;
      $display("FAIL ramp_pwm high1 %0d want 15 high2 %0d want 0", h1, h2);
    end
  endtask

  task automatic test_reverse();
    int cyc, last1, first2, h1, h2;
    bit ovl;
    choose_a[1:0] = 2'b10;
    @(negedge clk);
    n_chk++;
    if (busy_a[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rev_busy got %b want 1", busy_a[0]);
    end
    cyc = 0;
    last1 = -1;
    first2 = -1;
    ovl = 1'b0;
    repeat (7000) begin
      @(negedge clk);
      cyc++;
      if (pwm1_a[0]) last1 = cyc;
      if (pwm2_a[0] && first2 < 0) first2 = cyc;
      if ((pwm1_a & pwm2_a) != '0) ovl = 1'b1;
      n_chk++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        n_err++;
        $display("FAIL reverse a=%h want %h b=%h want %h", obs_a, exp_a, obs_b, exp_b);
      end
    end
    n_chk++;
    if (ovl) begin
      n_err++;
      $display("FAIL rev_overlap got both-high want never");
    end
    n_chk++;
    if (first2 < 0 || first2 - last1 - 1 < D_A) begin
      n_err++;
      $display("FAIL rev_dead gap %0d want >= %0d", first2 - last1 - 1, D_A);
    end
    h1 = 0;
    h2 = 0;
    repeat (P_A) begin
      @(negedge clk);
      if (pwm1_a[0]) h1++;
      if (pwm2_a[0]) h2++;
    end
    n_chk++;
    if (da(0) != 15 || h1 != 0 || h2 != 15) begin
      n_err++;
      $display("FAIL rev_final duty %0d h1 %0d h2 %0d want 15 0 15", da(0), h1, h2);
    end
  endtask

  task automatic test_brake();
    speed_a[1:0] = 2'd2;
    repeat (1200) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a) begin
        n_err++;
        $display("FAIL brake_pre a=%h want %h", obs_a, exp_a);
      end
    end
    n_chk++;
    if (da(0) != 10) begin
      n_err++;
      $display("FAIL brake_duty10 got %0d want 10", da(0));
    end
    choose_a[1:0] = 2'b00;
    @(negedge clk);
    n_chk++;
    if (da(0) != 0 || pwm1_a[0] || pwm2_a[0] || busy_a[0]) begin
      n_err++;
      $display("FAIL brake00 duty %0d p1 %b p2 %b busy %b want all 0",
               da(0), pwm1_a[0], pwm2_a[0], busy_a[0]);
    end
    choose_a[1:0] = 2'b01;
    repeat (900) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a) begin
        n_err++;
        $display("FAIL brake_rerun a=%h want %h", obs_a, exp_a);
      end
    end
    n_chk++;
    if (da(0) == 0) begin
      n_err++;
      $display("FAIL brake_rerun_duty got 0 want nonzero");
    end
    choose_a[1:0] = 2'b11;
    @(negedge clk);
    n_chk++;
    if (da(0) != 0 || pwm1_a[0] || pwm2_a[0] || busy_a[0]) begin
      n_err++;
      $display("FAIL brake11 duty %0d p1 %b p2 %b busy %b want all 0",
               da(0), pwm1_a[0], pwm2_a[0], busy_a[0]);
    end
  endtask

  task automatic test_drain_back();
    int guard, mn;
    choose_a[1:0] = 2'b01;
    speed_a[1:0]  = 2'd2;
    repeat (2300) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a) begin
        n_err++;
        $display("FAIL dback_up a=%h want %h", obs_a, exp_a);
      end
    end
    n_chk++;
    if (da(0) != 10) begin
      n_err++;
      $display("FAIL dback_duty got %0d want 10", da(0));
    end
    choose_a[1:0] = 2'b10;
    guard = 0;
    while (da(0) != 7 && guard < 1200) begin
      @(negedge clk);
      guard++;
      n_chk++;
      if (obs_a !== exp_a) begin
        n_err++;
        $display("FAIL dback_drain a=%h want %h", obs_a, exp_a);
      end
    end
    n_chk++;
    if (guard >= 1200) begin
      n_err++;
      $display("FAIL dback_timeout duty %0d want 7", da(0));
    end
    choose_a[1:0] = 2'b01;
    @(negedge clk);
    n_chk++;
    if (busy_a[0] !== 1'b0 || da(0) != 7) begin
      n_err++;
      $display("FAIL dback_resume busy %b duty %0d want 0 7", busy_a[0], da(0));
    end
    mn = 99;
    repeat (800) begin
      @(negedge clk);
      if (da(0) < mn) mn = da(0);
      n_chk++;
      if (obs_a !== exp_a) begin
        n_err++;
        $display("FAIL dback_ramp a=%h want %h", obs_a, exp_a);
      end
    end
    n_chk++;
    if (mn < 7 || da(0) != 10) begin
      n_err++;
      $display("FAIL dback_final min %0d duty %0d want >=7 10", mn, da(0));
    end
  endtask

  task automatic test_wide();
    int h;
    bit other_moved, ovl;
    choose_b = {2'b00, 2'b01, 2'b10, 2'b01};
    speed_b  = {2'd3, 2'd3, 2'd2, 2'd1};
    repeat (2000) begin
      @(negedge clk);
      n_chk++;
      if (obs_b !== exp_b) begin
        n_err++;
        $display("FAIL wide_up b=%h want %h", obs_b, exp_b);
      end
    end
    h = 0;
    repeat (P_B) begin
      @(negedge clk);
      if (pwm1_b[2]) h++;
    end
    n_chk++;
    if (db(2) != 20 || h != 20) begin
      n_err++;
      $display("FAIL wide_clamp duty %0d high %0d want 20 20", db(2), h);
    end
    n_chk++;
    if (db(0) != 10 || db(1) != 20 || db(3) != 0) begin
      n_err++;
      $display("FAIL wide_others %0d %0d %0d want 10 20 0", db(0), db(1), db(3));
    end
    choose_b[5:4] = 2'b10;
    other_moved = 1'b0;
    ovl = 1'b0;
    repeat (3600) begin
      @(negedge clk);
      if (db(0) != 10 || db(1) != 20 || busy_b[0] || busy_b[1]) other_moved = 1'b1;
      if ((pwm1_b & pwm2_b) != '0) ovl = 1'b1;
      n_chk++;
      if (obs_b !== exp_b) begin
        n_err++;
        $display("FAIL wide_rev b=%h want %h", obs_b, exp_b);
      end
    end
    n_chk++;
    if (other_moved || ovl) begin
      n_err++;
      $display("FAIL wide_indep moved %b overlap %b want 0 0", other_moved, ovl);
    end
    h = 0;
    repeat (P_B) begin
      @(negedge clk);
      if (pwm2_b[2]) h++;
    end
    n_chk++;
    if (db(2) != 20 || h != 20) begin
      n_err++;
      $display("FAIL wide_revfinal duty %0d high %0d want 20 20", db(2), h);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    choose_a[1:0] = 2'b10;
    guard = 0;
    while (!(busy_a[0] && da(0) == 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
      n_chk++;
      if (obs_a !== exp_a) begin
        n_err++;
        $display("FAIL arst_drain a=%h want %h", obs_a, exp_a);
      end
    end
    n_chk++;
    if (guard >= 3000) begin
      n_err++;
      $display("FAIL arst_timeout busy %b duty %0d", busy_a[0], da(0));
    end
    repeat (30) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_chk++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_err++;
      $display("FAIL arst_async a=%h b=%h want 0", obs_a, obs_b);
    end
    choose_a = '0;
    choose_b = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (300) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        n_err++;
        $display("FAIL arst_idle a=%h want %h b=%h want %h", obs_a, exp_a, obs_b, exp_b);
      end
    end
    n_chk++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_err++;
      $display("FAIL arst_stop a=%h b=%h want 0", obs_a, obs_b);
    end
  endtask

  task automatic test_random();
    int hold;
    bit ovl;
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < CH_A; i++) begin
        choose_a[2*i +: 2] = rand_dir();
        speed_a[SW*i +: SW] = 2'($urandom_range(0, 3));
      end
      for (int j = 0; j < CH_B; j++) begin
        choose_b[2*j +: 2] = rand_dir();
        speed_b[SW*j +: SW] = 2'($urandom_range(0, 3));
      end
      hold = int'($urandom_range(100, 1500));
      ovl = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if ((pwm1_a & pwm2_a) != '0 || (pwm1_b & pwm2_b) != '0) ovl = 1'b1;
        n_chk++;
        if (obs_a !== exp_a || obs_b !== exp_b) begin
          n_err++;
          $display("FAIL random a=%h want %h b=%h want %h", obs_a, exp_a, obs_b, exp_b);
        end
      end
      n_chk++;
      if (ovl) begin
        n_err++;
        $display("FAIL random_overlap seg %0d got both-high want never", s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reverse();
    test_brake();
    test_drain_back();
    test_wide();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
